// File: rtl/ram_emu_pkg.sv
// ram_emu_pkg: shared tag encoding and default bus widths for the RAM emulator
package ram_emu_pkg;
  localparam int ADDR_BITS_DEF = 16;
  localparam int DATA_BITS_DEF = 16;
  localparam logic TAG_VID = 1'b0;
  localparam logic TAG_AUX = 1'b1;
endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester, link and status signals of the RAM port arbiter
interface ram_port_arbiter_if import ram_emu_pkg::*; #(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int MAX_OUTSTANDING = 4
);
  localparam int CNT_BITS = $clog2(MAX_OUTSTANDING + 1);
  logic                 vid_req_valid;
  logic [ADDR_BITS-1:0] vid_req_addr;
  logic                 vid_req_ready;
  logic                 aux_req_valid;
  logic [ADDR_BITS-1:0] aux_req_addr;
  logic                 aux_req_we;
  logic [DATA_BITS-1:0] aux_req_wdata;
  logic                 aux_req_ready;
  logic                 link_cmd_valid;
  logic                 link_cmd_ready;
  logic [ADDR_BITS-1:0] link_cmd_addr;
  logic                 link_cmd_we;
  logic [DATA_BITS-1:0] link_cmd_wdata;
  logic                 link_rsp_valid;
  logic [DATA_BITS-1:0] link_rsp_data;
  logic                 vid_rsp_valid;
  logic [DATA_BITS-1:0] vid_rsp_data;
  logic                 aux_rsp_valid;
  logic [DATA_BITS-1:0] aux_rsp_data;
  logic [CNT_BITS-1:0]  outstanding;
  logic                 err_unexpected_rsp;
  modport slave (
    input  vid_req_valid, vid_req_addr, aux_req_valid, aux_req_addr, aux_req_we, aux_req_wdata,
    input  link_cmd_ready, link_rsp_valid, link_rsp_data,
    output vid_req_ready, aux_req_ready, link_cmd_valid, link_cmd_addr, link_cmd_we, link_cmd_wdata,
    output vid_rsp_valid, vid_rsp_data, aux_rsp_valid, aux_rsp_data, outstanding, err_unexpected_rsp
  );
  modport master (
    output vid_req_valid, vid_req_addr, aux_req_valid, aux_req_addr, aux_req_we, aux_req_wdata,
    output link_cmd_ready, link_rsp_valid, link_rsp_data,
    input  vid_req_ready, aux_req_ready, link_cmd_valid, link_cmd_addr, link_cmd_we, link_cmd_wdata,
    input  vid_rsp_valid, vid_rsp_data, aux_rsp_valid, aux_rsp_data, outstanding, err_unexpected_rsp
  );
endinterface

// File: rtl/ram_port_arbiter_tag_fifo.sv
// tag_fifo: in-order FIFO of 1-bit requester tags for reads awaiting a link response
module tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic                         i_tag,
  input  logic                         i_pop,
  output logic                         o_tag,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [DEPTH-1:0] r_mem;
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign w_push  = i_push && r_count != CW'(DEPTH);
  assign w_pop   = i_pop && r_count != '0;
  assign o_tag   = r_mem[r_rd];
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_tag;
        r_wr        <= nxt(r_wr);
      end
      if (w_pop) r_rd <= nxt(r_rd);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: arbitrates video/aux requests onto one link command slot and routes read responses back
module ram_port_arbiter import ram_emu_pkg::*; #(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT = 3
) (
  input logic               clk,
  input logic               rst_n,
  ram_port_arbiter_if.slave bus
);
  localparam int CNT_BITS = $clog2(MAX_OUTSTANDING + 1);
  localparam int SC_BITS  = $clog2(STARVE_LIMIT + 1);
  logic [SC_BITS-1:0]   r_starve;
  logic                 r_cmd_valid;
  logic                 r_cmd_we;
  logic [ADDR_BITS-1:0] r_cmd_addr;
  logic [DATA_BITS-1:0] r_cmd_wdata;
  logic                 r_vid_rsp;
  logic                 r_aux_rsp;
  logic [DATA_BITS-1:0] r_rsp_data;
  logic                 r_err;
  logic                 w_slot_free;
  logic                 w_cap;
  logic                 w_aux_win;
  logic                 w_vid_gnt;
  logic                 w_aux_gnt;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_head_tag;
  logic                 w_empty;
  logic [CNT_BITS-1:0]  w_count;
  // capacity comes from the registered count, so a response popping this cycle frees nothing until next cycle
  assign w_slot_free = !r_cmd_valid || bus.link_cmd_ready;
  assign w_cap       = w_count < CNT_BITS'(MAX_OUTSTANDING);
  assign w_aux_win   = bus.aux_req_valid && (!bus.vid_req_valid || r_starve == SC_BITS'(STARVE_LIMIT));
  assign w_vid_gnt   = rst_n && w_slot_free && w_cap && bus.vid_req_valid && !w_aux_win;
  assign w_aux_gnt   = rst_n && w_slot_free && w_aux_win && (bus.aux_req_we || w_cap);
  assign w_push      = w_vid_gnt || (w_aux_gnt && !bus.aux_req_we);
  assign w_pop       = bus.link_rsp_valid && !w_empty;
  assign bus.vid_req_ready      = w_vid_gnt;
  assign bus.aux_req_ready      = w_aux_gnt;
  assign bus.link_cmd_valid     = r_cmd_valid;
  assign bus.link_cmd_we        = r_cmd_we;
  assign bus.link_cmd_addr      = r_cmd_addr;
  assign bus.link_cmd_wdata     = r_cmd_wdata;
  assign bus.vid_rsp_valid      = r_vid_rsp;
  assign bus.aux_rsp_valid      = r_aux_rsp;
  assign bus.vid_rsp_data       = r_rsp_data;
  assign bus.aux_rsp_data       = r_rsp_data;
  assign bus.outstanding        = w_count;
  assign bus.err_unexpected_rsp = r_err;
  tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tags (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_tag   (w_aux_gnt ? TAG_AUX : TAG_VID),
    .i_pop   (w_pop),
    .o_tag   (w_head_tag),
    .o_empty (w_empty),
    .o_count (w_count)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve    <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_we    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_vid_rsp   <= 1'b0;
      r_aux_rsp   <= 1'b0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_vid_gnt || w_aux_gnt) begin
        r_cmd_valid <= 1'b1;
        r_cmd_we    <= w_aux_gnt && bus.aux_req_we;
        r_cmd_addr  <= w_aux_gnt ? bus.aux_req_addr : bus.vid_req_addr;
        r_cmd_wdata <= w_aux_gnt ? bus.aux_req_wdata : '0;
      end else if (bus.link_cmd_ready) begin
        r_cmd_valid <= 1'b0;
      end
      r_starve <= (!bus.aux_req_valid || w_aux_gnt) ? '0 :
                  (w_vid_gnt && r_starve != SC_BITS'(STARVE_LIMIT)) ? r_starve + SC_BITS'(1) : r_starve;
      r_vid_rsp <= w_pop && w_head_tag == TAG_VID;
      r_aux_rsp <= w_pop && w_head_tag == TAG_AUX;
      if (w_pop) r_rsp_data <= bus.link_rsp_data;
      if (bus.link_rsp_valid && w_empty) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed stimulus with a link model and a scoreboard of expected responses
module tb_ram_port_arbiter;
  import ram_emu_pkg::*;
  typedef struct {int due; logic [15:0] data;} rsp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ram_port_arbiter_if #(.ADDR_BITS(16), .DATA_BITS(16), .MAX_OUTSTANDING(4)) bus();
  ram_port_arbiter #(.ADDR_BITS(16), .DATA_BITS(16), .MAX_OUTSTANDING(4), .STARVE_LIMIT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  rsp_t        link_q[$];
  logic [16:0] exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    rsp_dly = 3;
  bit    auto_rsp = 1'b1;
  bit    g_vid, g_aux;
  string glog = "";
  int    peak = 0;
  int    wait_cur = 0;
  int    wait_max = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [16:0] got;
    if (rst_n && (bus.vid_rsp_valid || bus.aux_rsp_valid)) begin
      got = {bus.aux_rsp_valid, bus.aux_rsp_valid ? bus.aux_rsp_data : bus.vid_rsp_data};
      chk("rsp_onehot", bus.vid_rsp_valid && bus.aux_rsp_valid, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got %0h expected no response", got);
      end else begin
        chk("rsp_data", got, exp_q.pop_front());
      end
    end
  end

  // one clock: link drives due responses, grants and accepted commands are recorded, then advance
  task automatic tick();
    if (auto_rsp) begin
      if (link_q.size() > 0 && link_q[0].due <= cyc) begin
        bus.link_rsp_valid = 1'b1;
        bus.link_rsp_data  = link_q[0].data;
        void'(link_q.pop_front());
      end else begin
        bus.link_rsp_valid = 1'b0;
      end
    end
    #1;
    g_vid = bus.vid_req_valid && bus.vid_req_ready;
    g_aux = bus.aux_req_valid && bus.aux_req_ready;
    if (rst_n) begin
      if (bus.link_cmd_valid && bus.link_cmd_ready && !bus.link_cmd_we)
        link_q.push_back('{cyc + rsp_dly, bus.link_cmd_addr ^ 16'hA100});
      if (g_vid) begin
        glog = {glog, "V"};
        exp_q.push_back({TAG_VID, bus.vid_req_addr ^ 16'hA100});
      end
      if (g_aux) begin
        glog = {glog, "A"};
        if (!bus.aux_req_we) exp_q.push_back({TAG_AUX, bus.aux_req_addr ^ 16'hA100});
      end
      wait_cur = (bus.aux_req_valid && !g_aux) ? wait_cur + 1 : 0;
      if (wait_cur > wait_max) wait_max = wait_cur;
      if (int'(bus.outstanding) > peak) peak = int'(bus.outstanding);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input bit aux, input bit we, input logic [15:0] addr, input logic [15:0] wd);
    bit got_g;
    got_g = 1'b0;
    if (aux) begin
      bus.aux_req_valid = 1'b1;
      bus.aux_req_we    = we;
      bus.aux_req_addr  = addr;
      bus.aux_req_wdata = wd;
    end else begin
      bus.vid_req_valid = 1'b1;
      bus.vid_req_addr  = addr;
    end
    for (int n = 0; n < 30 && !got_g; n++) begin
      tick();
      got_g = aux ? g_aux : g_vid;
    end
    chk("send_grant", got_g, 1);
    if (aux) bus.aux_req_valid = 1'b0;
    else bus.vid_req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && (exp_q.size() > 0 || link_q.size() > 0); n++) tick();
    tick();
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_cmd"}, {bus.link_cmd_valid, bus.link_cmd_we, bus.link_cmd_addr, bus.link_cmd_wdata}, 0);
    chk({name, "_rsp"}, {bus.vid_rsp_valid, bus.aux_rsp_valid, bus.vid_rsp_data, bus.aux_rsp_data,
                         bus.outstanding, bus.err_unexpected_rsp}, 0);
    chk({name, "_ready"}, {bus.vid_req_ready, bus.aux_req_ready}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.vid_req_valid = 0; bus.vid_req_addr = 0;
    bus.aux_req_valid = 0; bus.aux_req_addr = 0; bus.aux_req_we = 0; bus.aux_req_wdata = 0;
    bus.link_cmd_ready = 1; bus.link_rsp_valid = 0; bus.link_rsp_data = 0;
    @(negedge clk);
    bus.vid_req_valid = 1;
    bus.aux_req_valid = 1;
    tick();
    tick();
    chk_all_zero("reset");
    bus.vid_req_valid = 0;
    bus.aux_req_valid = 0;
    rst_n = 1;
    tick();
    // video reads with 3-cycle link latency
    rsp_dly = 3;
    peak = 0;
    for (int i = 0; i < 4; i++) send(0, 0, 16'h0100 + 16'(i), 0);
    drain();
    chk("peak_outstanding", peak >= 1 && peak <= 4, 1);
    // continuous contention
    rsp_dly = 1;
    glog = "";
    wait_cur = 0;
    wait_max = 0;
    bus.vid_req_valid = 1; bus.vid_req_addr = 16'h0200;
    bus.aux_req_valid = 1; bus.aux_req_we = 0; bus.aux_req_addr = 16'h2000;
    for (int n = 0; n < 40 && glog.len() < 8; n++) tick();
    bus.vid_req_valid = 0;
    bus.aux_req_valid = 0;
    checks++;
    if (glog != "VVVAVVVA") begin
      errors++;
      $display("FAIL grant_order: got %s expected VVVAVVVA", glog);
    end
    chk("aux_wait_le4", wait_max <= 4, 1);
    drain();
    // capacity limit, responses driven by hand
    auto_rsp = 0;
    bus.link_rsp_valid = 0;
    for (int i = 0; i < 4; i++) send(0, 0, 16'h0300 + 16'(i), 0);
    bus.vid_req_valid = 1;
    bus.vid_req_addr  = 16'h0304;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("cap_block", g_vid, 0);
    end
    chk("outst_full", bus.outstanding, 4);
    bus.link_rsp_valid = 1;
    bus.link_rsp_data  = link_q[0].data;
    void'(link_q.pop_front());
    tick();
    chk("grant_cycle_n", g_vid, 0);
    bus.link_rsp_valid = 0;
    tick();
    chk("grant_cycle_n1", g_vid, 1);
    bus.vid_req_valid = 0;
    chk("outst_after_refill", bus.outstanding, 4);
    auto_rsp = 1;
    rsp_dly = 3;
    drain();
    // stalled link with a pending aux write
    bus.link_cmd_ready = 0;
    send(1, 1, 16'h1234, 16'hBEEF);
    bus.vid_req_valid = 1;
    bus.vid_req_addr  = 16'h0400;
    for (int i = 0; i < 6; i++) begin
      chk("stall_cmd", {bus.link_cmd_valid, bus.link_cmd_we, bus.link_cmd_addr, bus.link_cmd_wdata},
          {1'b1, 1'b1, 16'h1234, 16'hBEEF});
      tick();
      chk("stall_vid_block", g_vid, 0);
      chk("stall_outst", bus.outstanding, 0);
    end
    bus.link_cmd_ready = 1;
    tick();
    chk("release_grant", g_vid, 1);
    bus.vid_req_valid = 0;
    drain();
    // response with nothing outstanding
    auto_rsp = 0;
    bus.link_rsp_valid = 1;
    bus.link_rsp_data  = 16'h7777;
    tick();
    bus.link_rsp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("err_sticky", bus.err_unexpected_rsp, 1);
    end
    auto_rsp = 1;
    // reset mid-operation
    send(0, 0, 16'h0500, 0);
    send(1, 0, 16'h0600, 0);
    bus.vid_req_valid = 1;
    bus.vid_req_addr  = 16'h0700;
    rst_n = 0;
    exp_q.delete();
    link_q.delete();
    bus.link_rsp_valid = 0;
    tick();
    chk_all_zero("midreset");
    bus.vid_req_valid = 0;
    rst_n = 1;
    tick();
    send(0, 0, 16'h0800, 0);
    drain();
    chk("post_reset_err", bus.err_unexpected_rsp, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameters: ADDR_BITS = 16 (request address width); DATA_BITS = 16 (data word width); MAX_OUTSTANDING = 4 (maximum in-flight reads); STARVE_LIMIT = 3 (consecutive video grants allowed while aux waits).
REQ-002 Port `clk`: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 Port `rst_n`: input, 1 bit, synchronous active-low reset.
REQ-004 Video request ports: `vid_req_valid` in 1; `vid_req_addr` in ADDR_BITS; `vid_req_ready` out 1. Video requests are read-only.
REQ-005 Aux request ports: `aux_req_valid` in 1; `aux_req_addr` in ADDR_BITS; `aux_req_we` in 1 (1 = write); `aux_req_wdata` in DATA_BITS; `aux_req_ready` out 1.
REQ-006 Link command ports (toward the serial RAM link transmitter): `link_cmd_valid` out 1; `link_cmd_ready` in 1; `link_cmd_addr` out ADDR_BITS; `link_cmd_we` out 1; `link_cmd_wdata` out DATA_BITS.
REQ-007 Link response ports: `link_rsp_valid` in 1; `link_rsp_data` in DATA_BITS. There is no backpressure on responses.
REQ-008 Requester response ports: `vid_rsp_valid` out 1, `vid_rsp_data` out DATA_BITS; `aux_rsp_valid` out 1, `aux_rsp_data` out DATA_BITS.
REQ-009 Status ports: `outstanding` out clog2(MAX_OUTSTANDING+1), the in-flight read count; `err_unexpected_rsp` out 1, sticky.

Function
REQ-010 Command register: a single registered slot, `link_cmd_*`, that accepts a new command when empty or when `link_cmd_valid && link_cmd_ready` in the same cycle.
REQ-011 While `link_cmd_valid=1` and `link_cmd_ready=0`, all `link_cmd_*` outputs hold stable.
REQ-012 Issue condition: slot can accept, AND (request is a write OR `outstanding < MAX_OUTSTANDING`).
- The check uses the registered count.
- A same-cycle response pop does not free capacity.
REQ-013 Ready outputs: `vid_req_ready`/`aux_req_ready` are combinational and assert only for the granted requester in a cycle meeting REQ-012. A transfer occurs on valid && ready.
REQ-014 Priority:
- Video wins by default.
- Aux wins if its request is valid and `starve_cnt == STARVE_LIMIT`.
- Aux wins if video is not valid.
REQ-015 `starve_cnt`:
- Increments (saturating at STARVE_LIMIT) on each video grant while `aux_req_valid=1`.
- Clears on any aux grant, or on any cycle with `aux_req_valid=0`.
REQ-016 Each granted read pushes a 1-bit tag (0 = video, 1 = aux) into an in-order tag FIFO of depth MAX_OUTSTANDING. Writes push no tag.
REQ-017 Response routing:
- When `link_rsp_valid=1` and the FIFO is non-empty, the FIFO pops.
- Next cycle, the tagged requester's `*_rsp_valid` pulses for 1 cycle with the registered `link_rsp_data`.
- Latency is 1 cycle.
REQ-018 Simultaneous push and pop in one cycle: both take effect; `outstanding` is unchanged.
REQ-019 Response with an empty FIFO: the response is dropped, no `*_rsp_valid` pulses, and `err_unexpected_rsp` sets to 1 until reset.
REQ-020 Tag FIFO pointers wrap modulo MAX_OUTSTANDING. `outstanding` never exceeds MAX_OUTSTANDING.
REQ-021 `vid_rsp_valid` and `aux_rsp_valid` are never asserted in the same cycle.

Reset
REQ-022 When `rst_n=0` at a clock edge:
- All outputs go to 0: `link_cmd_valid`, `link_cmd_*`, `*_rsp_valid`, `*_rsp_data`, `outstanding`, `err_unexpected_rsp`.
- `starve_cnt` and FIFO pointers go to 0.
REQ-023 Reset mid-operation discards the pending command and all outstanding tags.
- The first response after reset is treated as unexpected per REQ-019.
- The bench resets the link model together with this block.
REQ-024 Ready outputs are 0 while `rst_n=0`.

Structure
REQ-025 Shared package `ram_emu_pkg` holds the tag encoding constants (TAG_VID, TAG_AUX) and the default ADDR_BITS/DATA_BITS values.
REQ-026 The tag FIFO is one sub-module, `tag_fifo`, parameterized by depth. Arbitration, the command slot and response routing live in the top module.

Verification
REQ-027 Video reads only, 0x0100..0x0103, `link_cmd_ready=1`, responses 0xA000..0xA003 at 3-cycle delay -> 4 `vid_rsp_valid` pulses in order with data A000..A003; `outstanding` peaks at ≤4.
REQ-028 Video and aux both valid continuously, always ready -> grant order V,V,V,A,V,V,V,A; aux never waits more than 4 cycles.
REQ-029 5 reads issued, no responses -> 5th read not granted and `outstanding=4`; one response in cycle N -> 5th read granted in cycle N+1, not N.
REQ-030 `link_cmd_ready=0` for 6 cycles with an aux write to 0x1234/0xBEEF pending -> `link_cmd_*` stable all 6 cycles; no tag pushed; `outstanding` unchanged.
REQ-031 `link_rsp_valid` pulsed with `outstanding=0` -> no `*_rsp_valid`; `err_unexpected_rsp=1` and held until `rst_n=0`.
REQ-032 Interleaved V-read, A-read, V-read; reset asserted after the 2nd grant -> all outputs 0 the cycle after reset; after release, a new video read completes normally.
